// File: rtl/dispatch_stage_if.sv
// Decoder-to-dispatch, dispatch-to-issue-queue and exception handshake bundle.
// master: the surrounding pipeline (decoder, issue queues, exception handler).
// slave : the dispatch stage itself.
interface dispatch_stage_if #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned INST_SIZE  = 32,
    parameter int unsigned NUM_QUEUES = 4
);
    // Decoder side
    logic                  dec_valid_i;
    logic                  dec_ready_o;
    logic [INST_SIZE-1:0]  dec_instr_i;
    logic [XLEN-1:0]       dec_pc_i;
    logic [2:0]            dec_queue_i;
    logic [3:0]            dec_fu_i;
    logic                  dec_illegal_i;

    // Issue-queue side (payload shared by all queues)
    logic [NUM_QUEUES-1:0] disp_valid_o;
    logic [NUM_QUEUES-1:0] disp_ready_i;
    logic [INST_SIZE-1:0]  disp_instr_o;
    logic [XLEN-1:0]       disp_pc_o;
    logic [3:0]            disp_fu_o;

    // Exception side
    logic                  exc_valid_o;
    logic                  exc_ready_i;
    logic [XLEN-1:0]       exc_pc_o;
    logic [XLEN-1:0]       exc_tval_o;

    modport master (
        output dec_valid_i, dec_instr_i, dec_pc_i, dec_queue_i, dec_fu_i, dec_illegal_i,
        output disp_ready_i, exc_ready_i,
        input  dec_ready_o, disp_valid_o, disp_instr_o, disp_pc_o, disp_fu_o,
        input  exc_valid_o, exc_pc_o, exc_tval_o
    );

    modport slave (
        input  dec_valid_i, dec_instr_i, dec_pc_i, dec_queue_i, dec_fu_i, dec_illegal_i,
        input  disp_ready_i, exc_ready_i,
        output dec_ready_o, disp_valid_o, disp_instr_o, disp_pc_o, disp_fu_o,
        output exc_valid_o, exc_pc_o, exc_tval_o
    );
endinterface

// File: rtl/dispatch_stage.sv
// Dispatch stage: buffers decoded micro-ops in a small FIFO and routes the head,
// in program order, to its target issue queue; illegal/unroutable ops go to the
// exception port and dispatch halts until a flush.
// Ports:
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   flush_i        pipeline flush, highest priority
//   bus            decoder / issue-queue / exception handshakes (slave side)
//   occupancy_o    registered FIFO entry count
// dec_ready_o is a flop gated only by flush_i; valids and payloads are decoded
// combinationally from the registered head entry.
module dispatch_stage #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned INST_SIZE  = 32,
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         flush_i,
    dispatch_stage_if.slave              bus,
    output logic [$clog2(BUF_DEPTH):0]   occupancy_o
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned QID_W = 3;

    typedef logic [PTR_W:0]   ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic                 illegal;
        logic [QID_W-1:0]     queue;
        logic [3:0]           fu;
        logic [XLEN-1:0]      pc;
        logic [INST_SIZE-1:0] instr;
    } entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e state_q, state_d;
    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    cnt_t   cnt_q, cnt_d;
    logic   ready_q, ready_d;
    entry_t mem_q [BUF_DEPTH];

    entry_t                head;
    entry_t                dec_entry;
    logic                  empty;
    logic                  head_live;
    logic                  head_exc;
    logic                  push;
    logic                  pop;
    logic                  dec_ready;
    logic                  exc_valid;
    logic [NUM_QUEUES-1:0] disp_valid;

    // Head decode and handshake qualification
    always_comb begin
        dec_entry  = '{illegal: bus.dec_illegal_i, queue: bus.dec_queue_i, fu: bus.dec_fu_i,
                       pc: bus.dec_pc_i, instr: bus.dec_instr_i};
        empty      = (wr_ptr_q == rd_ptr_q);
        head       = mem_q[rd_ptr_q[PTR_W-1:0]];
        // Valids are suppressed during a flush so downstream never acts on a discarded handshake
        head_live  = (state_q == RUN) && !empty && !flush_i;
        head_exc   = head.illegal || (32'(head.queue) >= NUM_QUEUES);
        exc_valid  = head_live && head_exc;
        disp_valid = '0;
        for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
            if (head_live && !head_exc && (head.queue == QID_W'(i))) begin
                disp_valid[i] = 1'b1;
            end
        end
        dec_ready  = ready_q && !flush_i;
        push       = bus.dec_valid_i && dec_ready;
        pop        = (exc_valid && bus.exc_ready_i) || (|(disp_valid & bus.disp_ready_i));
    end

    // Next-state: pointers, count, FSM and next-cycle ready
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            state_d  = RUN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
            cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);
            if (exc_valid && bus.exc_ready_i) state_d = HALT;
        end
        // Ready is precomputed from next-cycle state so it never depends on disp_ready_i
        ready_d = (state_d == RUN) && (cnt_d != cnt_t'(BUF_DEPTH));
    end

    // Control registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= dec_entry;
        end
    end

    // Outputs; payloads read as zero when the buffer is empty
    assign bus.dec_ready_o  = dec_ready;
    assign bus.disp_valid_o = disp_valid;
    assign bus.exc_valid_o  = exc_valid;
    assign bus.disp_instr_o = empty ? '0 : head.instr;
    assign bus.disp_pc_o    = empty ? '0 : head.pc;
    assign bus.disp_fu_o    = empty ? '0 : head.fu;
    assign bus.exc_pc_o     = empty ? '0 : head.pc;
    assign bus.exc_tval_o   = empty ? '0 : XLEN'(head.instr);
    assign occupancy_o      = cnt_q;

endmodule
